// File: rtl/decode_stage.sv
// Decode stage of a five-stage MIPS-style pipeline: IF/ID register, 32x32 register file with
// write-first bypass, main/ALU decoder, early branch compare and branch/jump target generation.
module decode_stage (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  output logic        RegWriteD,
  output logic        MemToRegD,
  output logic        MemWriteD,
  output logic        ALUSrcD,
  output logic        RegDstD,
  output logic        BranchD,
  output logic        JumpD,
  output logic [2:0]  ALUControlD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] SignImmD,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] PCJumpD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] cmp_a, cmp_b;

  // Flush wins over stall so a squashed slot never lingers behind a stall.
  always_comb begin
    instr_d   = InstrF;
    pcplus4_d = PCPlus4F;
    if (FlushD) begin
      instr_d   = '0;
      pcplus4_d = '0;
    end else if (StallD) begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign rf_we = RegWriteW && (WriteRegW != 5'd0);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

  assign RsD      = instr_q[25:21];
  assign RtD      = instr_q[20:16];
  assign RdD      = instr_q[15:11];
  assign SignImmD = {{16{instr_q[15]}}, instr_q[15:0]};

  // Writeback data is visible in the same cycle it is written (write-first).
  always_comb begin
    RD1D = rf_q[RsD];
    if (RsD == 5'd0)                      RD1D = '0;
    else if (rf_we && (WriteRegW == RsD)) RD1D = ResultW;
  end

  always_comb begin
    RD2D = rf_q[RtD];
    if (RtD == 5'd0)                      RD2D = '0;
    else if (rf_we && (WriteRegW == RtD)) RD2D = ResultW;
  end

  always_comb begin
    RegWriteD   = 1'b0;
    MemToRegD   = 1'b0;
    MemWriteD   = 1'b0;
    ALUSrcD     = 1'b0;
    RegDstD     = 1'b0;
    BranchD     = 1'b0;
    JumpD       = 1'b0;
    ALUControlD = 3'b000;
    case (instr_q[31:26])
      6'b000000: begin
        // Unknown funct (including the all-zero bubble) decodes as a full nop.
        RegWriteD = 1'b1;
        RegDstD   = 1'b1;
        case (instr_q[5:0])
          6'b100000: ALUControlD = 3'b010;
          6'b100010: ALUControlD = 3'b110;
          6'b100100: ALUControlD = 3'b000;
          6'b100101: ALUControlD = 3'b001;
          6'b101010: ALUControlD = 3'b111;
          default: begin
            RegWriteD = 1'b0;
            RegDstD   = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        MemToRegD   = 1'b1;
        ALUControlD = 3'b010;
      end
      6'b101011: begin
        MemWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = 3'b010;
      end
      6'b000100: begin
        BranchD     = 1'b1;
        ALUControlD = 3'b110;
      end
      6'b001000: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = 3'b010;
      end
      6'b000010: JumpD = 1'b1;
      default: ;
    endcase
  end

  assign cmp_a     = ForwardAD ? ALUOutM : RD1D;
  assign cmp_b     = ForwardBD ? ALUOutM : RD2D;
  assign PCSrcD    = BranchD && (cmp_a == cmp_b);
  assign PCBranchD = pcplus4_q + {SignImmD[29:0], 2'b00};
  assign PCJumpD   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a behavioural model of the pipeline register and register
// file predicts every output each cycle, plus directed scenarios with hand-computed values.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrF = '0, PCPlus4F = '0;
  logic        StallD = 1'b0, FlushD = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  WriteRegW = '0;
  logic [31:0] ResultW = '0;
  logic        ForwardAD = 1'b0, ForwardBD = 1'b0;
  logic [31:0] ALUOutM = '0;

  logic        RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD, PCBranchD, PCJumpD;
  logic [4:0]  RsD, RtD, RdD;
  logic        PCSrcD;

  decode_stage dut (
    .CLK(CLK), .rst_n(rst_n), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .FlushD(FlushD), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .RegDstD(RegDstD), .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- model state and scoreboard ----------------
  typedef struct packed {
    logic rw, m2r, mw, src, dst, br, jmp;
    logic [2:0] alu;
  } ctl_t;

  logic [31:0] m_instr, m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic ctl_t ctl_of(input logic [31:0] ins);
    ctl_t c = '0;
    unique case (ins[31:26])
      6'h00: begin
        if      (ins[5:0] == 6'h20) begin c.rw = 1; c.dst = 1; c.alu = 3'd2; end
        else if (ins[5:0] == 6'h22) begin c.rw = 1; c.dst = 1; c.alu = 3'd6; end
        else if (ins[5:0] == 6'h24) begin c.rw = 1; c.dst = 1; c.alu = 3'd0; end
        else if (ins[5:0] == 6'h25) begin c.rw = 1; c.dst = 1; c.alu = 3'd1; end
        else if (ins[5:0] == 6'h2a) begin c.rw = 1; c.dst = 1; c.alu = 3'd7; end
      end
      6'h23: begin c.rw = 1; c.src = 1; c.m2r = 1; c.alu = 3'd2; end
      6'h2b: begin c.mw = 1; c.src = 1; c.alu = 3'd2; end
      6'h04: begin c.br = 1; c.alu = 3'd6; end
      6'h08: begin c.rw = 1; c.src = 1; c.alu = 3'd2; end
      6'h02: c.jmp = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWriteW && WriteRegW == idx) return ResultW;
    return m_rf[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic check_all();
    ctl_t c;
    logic [31:0] r1, r2, a, b, simm;
    c    = ctl_of(m_instr);
    r1   = m_read(m_instr[25:21]);
    r2   = m_read(m_instr[20:16]);
    simm = 32'($signed(m_instr[15:0]));
    a    = ForwardAD ? ALUOutM : r1;
    b    = ForwardBD ? ALUOutM : r2;
    exp_q.push_back({22'd0, c});
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    exp_q.push_back(32'(m_instr[25:21]));
    exp_q.push_back(32'(m_instr[20:16]));
    exp_q.push_back(32'(m_instr[15:11]));
    exp_q.push_back(simm);
    exp_q.push_back(32'(c.br && (a == b)));
    exp_q.push_back(m_pc + 32'(int'($signed(m_instr[15:0])) * 4));
    exp_q.push_back((m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2));
    chk("ctrl", {22'd0, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD, ALUControlD});
    chk("RD1D", RD1D);
    chk("RD2D", RD2D);
    chk("RsD", 32'(RsD));
    chk("RtD", 32'(RtD));
    chk("RdD", 32'(RdD));
    chk("SignImmD", SignImmD);
    chk("PCSrcD", 32'(PCSrcD));
    chk("PCBranchD", PCBranchD);
    chk("PCJumpD", PCJumpD);
  endtask

  task automatic model_clear();
    m_instr = '0;
    m_pc    = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  task automatic model_update();
    if (RegWriteW && WriteRegW != 0) m_rf[WriteRegW] = ResultW;
    if (FlushD) begin
      m_instr = '0;
      m_pc    = '0;
    end else if (!StallD) begin
      m_instr = InstrF;
      m_pc    = PCPlus4F;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge CLK);
    check_all();
  endtask

  task automatic adv();
    @(posedge CLK);
    if (rst_n) model_update();
    #1;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    ins = $urandom();
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0, 1: begin
        ins[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: ins[5:0] = 6'h20;
          1: ins[5:0] = 6'h22;
          2: ins[5:0] = 6'h24;
          3: ins[5:0] = 6'h25;
          4: ins[5:0] = 6'h2a;
          default: ;
        endcase
      end
      2: ins[31:26] = 6'h23;
      3: ins[31:26] = 6'h2b;
      4: ins[31:26] = 6'h04;
      5: ins[31:26] = 6'h08;
      6: ins[31:26] = 6'h02;
      default: ;
    endcase
    return ins;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_clear();

    // Reset state
    settle();
    lit("rst_ctrl", {22'd0, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD, ALUControlD}, 32'd0);
    lit("rst_pcbranch", PCBranchD, 32'd0);
    adv();
    rst_n = 1'b1;

    // lw $2,4($1)
    InstrF = 32'h8C22_0004; PCPlus4F = 32'd4;
    settle(); adv();
    StallD = 1'b1;
    settle();
    lit("lw_regwrite", 32'(RegWriteD), 32'd1);
    lit("lw_alusrc", 32'(ALUSrcD), 32'd1);
    lit("lw_memtoreg", 32'(MemToRegD), 32'd1);
    lit("lw_aluctl", 32'(ALUControlD), 32'd2);
    lit("lw_rs", 32'(RsD), 32'd1);
    lit("lw_rt", 32'(RtD), 32'd2);
    lit("lw_simm", SignImmD, 32'd4);
    adv();

    // Write-first bypass on rs=5, then persistence, then $0 write ignored
    StallD = 1'b0; InstrF = 32'h00A0_0820;
    settle(); adv();
    StallD = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hDEAD_BEEF;
    settle();
    lit("bypass_rd1", RD1D, 32'hDEAD_BEEF);
    adv();
    RegWriteW = 1'b0; ResultW = '0;
    settle();
    lit("stored_rd1", RD1D, 32'hDEAD_BEEF);
    adv();
    RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h1234_5678;
    settle();
    lit("r0_bypass", RD2D, 32'd0);
    adv();
    RegWriteW = 1'b0;
    settle();
    lit("r0_stored", RD2D, 32'd0);
    adv();

    // beq $3,$4,-1 with $3=$4=7
    RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'd7;
    settle(); adv();
    WriteRegW = 5'd4;
    settle(); adv();
    RegWriteW = 1'b0; StallD = 1'b0; InstrF = 32'h1064_FFFF; PCPlus4F = 32'h100;
    settle(); adv();
    StallD = 1'b1;
    settle();
    lit("beq_taken", 32'(PCSrcD), 32'd1);
    lit("beq_target", PCBranchD, 32'h0000_00FC);
    adv();
    ForwardAD = 1'b1; ALUOutM = 32'd8;
    settle();
    lit("beq_fwd_nottaken", 32'(PCSrcD), 32'd0);
    adv();
    ForwardAD = 1'b0; ALUOutM = '0;

    // Stall holds across changing InstrF; flush beats stall
    StallD = 1'b0; InstrF = 32'hAC65_00F0; PCPlus4F = 32'h200;
    settle(); adv();
    StallD = 1'b1;
    for (int k = 0; k < 2; k++) begin
      InstrF = $urandom(); PCPlus4F = $urandom();
      settle();
      lit("stall_memwrite", 32'(MemWriteD), 32'd1);
      lit("stall_rt", 32'(RtD), 32'd5);
      lit("stall_simm", SignImmD, 32'h0000_00F0);
      adv();
    end
    FlushD = 1'b1;
    settle(); adv();
    FlushD = 1'b0;
    settle();
    lit("flush_ctrl", {22'd0, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD, ALUControlD}, 32'd0);
    lit("flush_rs", 32'(RsD), 32'd0);
    adv();

    // j 0x0000010, then an unknown opcode
    StallD = 1'b0; InstrF = 32'h0800_0010; PCPlus4F = 32'hF000_0004;
    settle(); adv();
    StallD = 1'b1;
    settle();
    lit("j_jump", 32'(JumpD), 32'd1);
    lit("j_target", PCJumpD, 32'hF000_0040);
    adv();
    StallD = 1'b0; InstrF = 32'hFC00_0000;
    settle(); adv();
    settle();
    lit("op3f_ctrl", {22'd0, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD, ALUControlD}, 32'd0);
    adv();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      InstrF    = gen_instr();
      PCPlus4F  = $urandom();
      StallD    = ($urandom_range(0, 7) == 0);
      FlushD    = ($urandom_range(0, 15) == 0);
      RegWriteW = $urandom_range(0, 1);
      WriteRegW = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 7));
      ResultW   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      ForwardAD = ($urandom_range(0, 3) == 0);
      ForwardBD = ($urandom_range(0, 3) == 0);
      ALUOutM   = 32'($urandom_range(0, 3));
      settle(); adv();
    end

    // Reset asserted mid-stall and mid-flush with a write pending
    for (int mode = 0; mode < 2; mode++) begin
      StallD = (mode == 0); FlushD = (mode == 1);
      RegWriteW = 1'b1; WriteRegW = 5'd9; ResultW = 32'hAAAA_5555;
      ForwardAD = 1'b0; ForwardBD = 1'b0;
      rst_n = 1'b0;
      #1;
      model_clear();
      settle();
      lit("rst_mid_rs", 32'(RsD), 32'd0);
      adv();
      rst_n = 1'b1; RegWriteW = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      InstrF = 32'h0120_0020; PCPlus4F = 32'h40;
      settle(); adv();
      StallD = 1'b1;
      settle();
      lit("rst_no_write", RD1D, 32'd0);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock, rising-edge active
- rst_n  in  1  reset, asynchronous, active-low
- InstrF  in  32  fetched instruction
- PCPlus4F  in  32  fetch PC+4
- StallD  in  1  hold IF/ID register
- FlushD  in  1  synchronous clear of IF/ID register
- RegWriteW  in  1  writeback enable
- WriteRegW  in  5  writeback register index
- ResultW  in  32  writeback data
- ForwardAD, ForwardBD  in  1 each  select ALUOutM for branch-compare operand A/B
- ALUOutM  in  32  memory-stage ALU result
- RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD  out  1 each  decoded controls
- ALUControlD  out  3  ALU operation
- RD1D, RD2D  out  32  register-file read data (rs, rt)
- RsD, RtD, RdD  out  5  InstrD[25:21], [20:16], [15:11]
- SignImmD  out  32  sign-extended InstrD[15:0]
- PCSrcD  out  1  branch taken
- PCBranchD, PCJumpD  out  32  branch / jump targets

Function
REQ-002 IF/ID register (InstrD, PCPlus4D, 32 bits each) SHALL update on rising CLK with InstrF/PCPlus4F.
REQ-003 FlushD=1 SHALL load InstrD=0, PCPlus4D=0 at the next edge; FlushD SHALL take priority over StallD.
REQ-004 StallD=1 (FlushD=0) SHALL hold InstrD and PCPlus4D unchanged.
REQ-005 Register file: 32 x 32 bits; write on rising CLK when RegWriteW=1 and WriteRegW!=0; writes to index 0 SHALL be ignored.
REQ-006 Reads SHALL be combinational; index 0 SHALL read 0.
REQ-007 Write-first bypass: if RegWriteW=1, WriteRegW!=0 and WriteRegW equals the read index, the read SHALL return ResultW in the same cycle.
REQ-008 Decode from opcode InstrD[31:26], unlisted controls 0:
- 000000 R-type: RegWrite=1, RegDst=1; funct 100000->ALU 010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct -> RegWrite=0, ALU 000
- 100011 lw: RegWrite, ALUSrc, MemToReg =1; ALU 010
- 101011 sw: MemWrite, ALUSrc =1; ALU 010
- 000100 beq: Branch=1; ALU 110
- 001000 addi: RegWrite, ALUSrc =1; ALU 010
- 000010 j: Jump=1
- other opcodes: all controls 0 (nop)
REQ-009 SignImmD SHALL be {16{InstrD[15]}, InstrD[15:0]}.
REQ-010 Branch compare: A = ForwardAD ? ALUOutM : RD1D; B = ForwardBD ? ALUOutM : RD2D; PCSrcD = BranchD & (A==B).
REQ-011 PCBranchD SHALL be PCPlus4D + (SignImmD<<2), modulo 2^32 (wrap, no flag).
REQ-012 PCJumpD SHALL be {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
REQ-013 RD1D/RD2D SHALL carry unforwarded register-file data; execute-stage forwarding is downstream.
REQ-014 All D outputs SHALL be combinational functions of IF/ID register, register file and forwarding inputs; latency InstrF -> D outputs = 1 cycle.

Reset
REQ-015 rst_n=0 SHALL asynchronously clear InstrD, PCPlus4D and all 32 registers to 0; all outputs then read 0 (InstrD=0 decodes as nop).
REQ-016 Reset deasserted mid-stall or mid-flush SHALL resume with cleared state; no pending write survives reset.

Verification
REQ-017 Reset, InstrF=0x8C220004 (lw $2,4($1)), 1 edge -> RegWriteD=1, ALUSrcD=1, MemToRegD=1, ALUControlD=010, RsD=1, RtD=2, SignImmD=4.
REQ-018 RegWriteW=1, WriteRegW=5, ResultW=0xDEADBEEF while InstrD reads rs=5 -> RD1D=0xDEADBEEF same cycle; next cycle still 0xDEADBEEF; WriteRegW=0 write -> $0 reads 0.
REQ-019 beq $3,$4,-1 with $3=$4=7, PCPlus4D=0x100 -> PCSrcD=1, PCBranchD=0xFC; ForwardAD=1 with ALUOutM=8 -> PCSrcD=0.
REQ-020 StallD=1 for 2 cycles while InstrF changes -> InstrD unchanged; FlushD=StallD=1 -> InstrD=0, all controls 0.
REQ-021 j 0x0000010 at PCPlus4D=0xF0000004 -> JumpD=1, PCJumpD=0xF0000040; opcode 111111 -> all controls 0.
